odu_chid_sched: RTL and testbench
=================================

ODU_CHID_SCHED -- requirements
Module: odu_chid_sched

Interface
REQ-001 Parameter NUM_CH, default 80, number of ODU channels arbitrated.
REQ-002 Parameter CHID_W, default 7, width of the channel ID; SHALL satisfy 2^CHID_W >= NUM_CH.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 i_enable_chid  input  NUM_CH  per-channel enable mask; bit n=1 admits channel n to arbitration.
REQ-006 i_req_chid  input  NUM_CH  per-channel request; bit n=1 means channel n holds a data word ready.
REQ-007 i_ready  input  1  downstream checker accepts the presented channel ID this cycle.
REQ-008 o_valid  output  1  a channel ID is presented.
REQ-009 o_chid  output  CHID_W  presented channel ID (binary, 0..NUM_CH-1).
REQ-010 o_ack_chid  output  NUM_CH  one-hot acknowledge to the requester accepted this cycle.
REQ-011 i_error_chid  input  NUM_CH  per-channel error pulses from the checker bank.
REQ-012 i_err_clr  input  1  clears all sticky error bits.
REQ-013 o_err_sticky  output  NUM_CH  sticky per-channel error status.
REQ-014 o_err_any  output  1  OR-reduction of o_err_sticky, registered.

Function
REQ-015 Eligible set SHALL be i_req_chid AND i_enable_chid.
REQ-016 Arbitration SHALL be round-robin: search starts at index last_grant+1, wraps from NUM_CH-1 to 0, selects first eligible channel.
REQ-017 last_grant SHALL update only on transfer (o_valid AND i_ready) to the transferred o_chid.
REQ-018 Two states: IDLE (o_valid=0) and HOLD (o_valid=1).
REQ-019 IDLE: if any channel eligible, next cycle o_valid=1 and o_chid=selection (1-cycle latency), go HOLD; else stay IDLE.
REQ-020 HOLD: o_chid SHALL remain stable until transfer; de-assertion of the held channel's req or enable SHALL NOT withdraw it.
REQ-021 HOLD with transfer: if another eligible channel exists (search excluding none, starting after transferred ID), load it next cycle and stay HOLD (back-to-back, one ID per cycle); else go IDLE.
REQ-022 o_ack_chid SHALL be one-hot at bit o_chid when o_valid AND i_ready, else all zeros; combinational from registered o_chid/o_valid and i_ready.
REQ-023 Single eligible channel SHALL be granted on every transfer cycle (no forced bubble).
REQ-024 i_ready while IDLE SHALL have no effect.
REQ-025 Eligible mask all zeros SHALL never assert o_valid.

Reset
REQ-026 rst SHALL drive o_valid=0, o_chid=0, state IDLE, last_grant=NUM_CH-1 (first search starts at channel 0).
REQ-027 rst SHALL clear o_err_sticky and o_err_any to 0.
REQ-028 rst asserted during HOLD SHALL drop the presented ID without transfer; no o_ack_chid that cycle is produced from the dropped state beyond REQ-022 with o_valid=0 after the edge.

Configuration
REQ-029 Macro ODU_SCHED_ERR_STICKY_EN defined: o_err_sticky bit n sets on i_error_chid[n]=1 when i_enable_chid[n]=1; cleared by i_err_clr; set wins over simultaneous clear; o_err_any follows one cycle later.
REQ-030 Macro undefined: sticky logic SHALL be absent; o_err_sticky tied 0, o_err_any tied 0; i_error_chid and i_err_clr ignored.

Verification
REQ-031 Reset, enable=all-ones, req=bits 3,10,79, i_ready=1 -> o_chid sequence 3,10,79,3,... one per cycle, first o_valid 1 cycle after req.
REQ-032 req=bit 5 only, i_ready=0 for 4 cycles then 1 -> o_chid=5 stable 5 cycles, o_ack_chid[5]=1 only on the ready cycle.
REQ-033 req=all-ones, enable=bit 0 only -> only o_chid=0 granted; switching enable to bit 40 mid-HOLD on ID 0 -> 0 still transferred, then 40.
REQ-034 HOLD on ID 78, i_ready=1, req bits 78,79,1 -> next IDs 79 then 1 (wrap-around verified).
REQ-035 With ODU_SCHED_ERR_STICKY_EN: i_error_chid[7] pulse and i_err_clr same cycle -> o_err_sticky[7]=1, o_err_any=1 one cycle later; lone i_err_clr later -> both 0; error on disabled channel 12 -> bit 12 stays 0.
REQ-036 rst asserted in HOLD on ID 20 -> next cycle o_valid=0, o_chid=0; after release with req bit 20 set, ID 20 re-presented starting search from 0.

Source files
------------

// File: rtl/odu_chid_sched.sv
// Round-robin channel-ID scheduler for the ODU checker bank.
// Presents one eligible channel ID at a time with a valid/ready handshake,
// holding it until accepted, and rotates fairly across all channels.
// Optional sticky error tracking is built when ODU_SCHED_ERR_STICKY_EN is defined.
module odu_chid_sched #(
  parameter int unsigned NUM_CH = 80,
  parameter int unsigned CHID_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] i_enable_chid,
  input  logic [NUM_CH-1:0] i_req_chid,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [CHID_W-1:0] o_chid,
  output logic [NUM_CH-1:0] o_ack_chid,
  input  logic [NUM_CH-1:0] i_error_chid,
  input  logic              i_err_clr,
  output logic [NUM_CH-1:0] o_err_sticky,
  output logic              o_err_any
);

  typedef enum logic {
    StIdle,
    StHold
  } state_e;

  state_e            state_q, state_d;
  logic [CHID_W-1:0] chid_q, chid_d;
  logic [CHID_W-1:0] last_q, last_d;

  logic [NUM_CH-1:0] elig;
  logic              xfer;
  logic [CHID_W-1:0] base;
  logic [CHID_W-1:0] start;
  logic [CHID_W-1:0] sel;
  logic              any_elig;
  logic [CHID_W-1:0] sel_lo, sel_hi, jj;
  logic              found_lo, found_hi;

  assign elig    = i_req_chid & i_enable_chid;
  assign o_valid = (state_q == StHold);
  assign o_chid  = chid_q;
  assign xfer    = o_valid & i_ready;

  // On a transfer the search restarts after the ID just accepted; that ID is
  // also last_grant from the next cycle, so both paths share one rule.
  assign base  = xfer ? chid_q : last_q;
  assign start = (base == CHID_W'(NUM_CH - 1)) ? '0 : base + 1'b1;

  // Round-robin pick: lowest eligible at or above start, else lowest overall (wrap).
  always_comb begin
    found_lo = 1'b0;
    found_hi = 1'b0;
    sel_lo   = '0;
    sel_hi   = '0;
    jj       = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      jj = CHID_W'(j);
      if (elig[jj]) begin
        if (!found_lo) begin
          found_lo = 1'b1;
          sel_lo   = jj;
        end
        if (!found_hi && (jj >= start)) begin
          found_hi = 1'b1;
          sel_hi   = jj;
        end
      end
    end
    any_elig = found_lo;
    sel      = found_hi ? sel_hi : sel_lo;
  end

  // Next-state: load a new ID from IDLE or straight after a transfer; otherwise hold.
  always_comb begin
    state_d = state_q;
    chid_d  = chid_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (any_elig) begin
          state_d = StHold;
          chid_d  = sel;
        end
      end
      StHold: begin
        if (xfer) begin
          last_d = chid_q;
          if (any_elig) begin
            chid_d = sel;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; last grant resets to the top channel so the first search starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      chid_q  <= '0;
      last_q  <= CHID_W'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      chid_q  <= chid_d;
      last_q  <= last_d;
    end
  end

  // Acknowledge the requester whose ID is accepted this cycle.
  always_comb begin
    o_ack_chid = '0;
    if (xfer) begin
      o_ack_chid = NUM_CH'(1) << chid_q;
    end
  end

`ifdef ODU_SCHED_ERR_STICKY_EN
  logic [NUM_CH-1:0] sticky_q;
  logic              any_q;

  // Sticky errors: a new error on an enabled channel wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
      any_q    <= 1'b0;
    end else begin
      sticky_q <= (sticky_q & ~{NUM_CH{i_err_clr}}) | (i_error_chid & i_enable_chid);
      any_q    <= |sticky_q;
    end
  end

  assign o_err_sticky = sticky_q;
  assign o_err_any    = any_q;
`else
  logic unused_err;
  assign unused_err   = ^{i_error_chid, i_err_clr};
  assign o_err_sticky = '0;
  assign o_err_any    = 1'b0;
`endif

endmodule

// File: tb/tb_odu_chid_sched.sv
// Self-checking bench for odu_chid_sched: directed vector table, a sticky-error
// sequence, and randomized traffic against a behavioural round-robin model.
module tb_odu_chid_sched;

  localparam int unsigned NUM_CH = 80;
  localparam int unsigned CHID_W = 7;

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] i_enable_chid;
  logic [NUM_CH-1:0] i_req_chid;
  logic              i_ready;
  logic              o_valid;
  logic [CHID_W-1:0] o_chid;
  logic [NUM_CH-1:0] o_ack_chid;
  logic [NUM_CH-1:0] i_error_chid;
  logic              i_err_clr;
  logic [NUM_CH-1:0] o_err_sticky;
  logic              o_err_any;

  odu_chid_sched #(
    .NUM_CH(NUM_CH),
    .CHID_W(CHID_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable_chid(i_enable_chid),
    .i_req_chid   (i_req_chid),
    .i_ready      (i_ready),
    .o_valid      (o_valid),
    .o_chid       (o_chid),
    .o_ack_chid   (o_ack_chid),
    .i_error_chid (i_error_chid),
    .i_err_clr    (i_err_clr),
    .o_err_sticky (o_err_sticky),
    .o_err_any    (o_err_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit              m_valid;
  int              m_chid;
  int              m_last;
  bit [NUM_CH-1:0] m_sticky;
  bit              m_any;

  // Sampled DUT outputs and model expectations for the current cycle
  logic              s_valid;
  logic [CHID_W-1:0] s_chid;
  logic [NUM_CH-1:0] s_ack;
  logic [NUM_CH-1:0] s_sticky;
  logic              s_any;
  logic              e_valid;
  int                e_chid;
  logic [NUM_CH-1:0] e_ack;
  logic [NUM_CH-1:0] e_sticky;
  logic              e_any;

  typedef struct {
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] req;
    logic              rdy;
    logic              chk;
    logic              ev;
    logic              cc;
    int                echid;
  } vec_t;

  vec_t tv[$];

  function automatic logic [NUM_CH-1:0] bit_of(input int n);
    logic [NUM_CH-1:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] req,
                     input logic rdy, input logic chk, input logic ev, input logic cc,
                     input int echid);
    vec_t v;
    v.rst = r; v.en = en; v.req = req; v.rdy = rdy;
    v.chk = chk; v.ev = ev; v.cc = cc; v.echid = echid;
    tv.push_back(v);
  endtask

  // Advance the model by one clock using the spec's rules directly.
  task automatic model_step(input logic r, input logic [NUM_CH-1:0] en,
                            input logic [NUM_CH-1:0] req, input logic rdy,
                            input logic [NUM_CH-1:0] err, input logic clr);
    bit [NUM_CH-1:0] el;
    bit              found;
    int              pick;
    int              c;
    if (r) begin
      m_valid  = 1'b0;
      m_chid   = 0;
      m_last   = NUM_CH - 1;
      m_sticky = '0;
      m_any    = 1'b0;
      return;
    end
    el = req & en;
    if (!m_valid || rdy) begin
      if (m_valid) m_last = m_chid;
      found = 1'b0;
      pick  = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (m_last + k) % NUM_CH;
        if (!found && el[c]) begin
          found = 1'b1;
          pick  = c;
        end
      end
      if (found) begin
        m_valid = 1'b1;
        m_chid  = pick;
      end else begin
        m_valid = 1'b0;
      end
    end
`ifdef ODU_SCHED_ERR_STICKY_EN
    m_any    = |m_sticky;
    m_sticky = (clr ? '0 : m_sticky) | (err & en);
`endif
  endtask

  // One clock: drive inputs, sample outputs at the falling edge, step the model.
  task automatic drive_cycle(input logic r, input logic [NUM_CH-1:0] en,
                             input logic [NUM_CH-1:0] req, input logic rdy,
                             input logic [NUM_CH-1:0] err, input logic clr);
    logic [NUM_CH-1:0] one;
    one           = 1;
    rst           = r;
    i_enable_chid = en;
    i_req_chid    = req;
    i_ready       = rdy;
    i_error_chid  = err;
    i_err_clr     = clr;
    @(negedge clk);
    s_valid  = o_valid;
    s_chid   = o_chid;
    s_ack    = o_ack_chid;
    s_sticky = o_err_sticky;
    s_any    = o_err_any;
    e_valid  = m_valid;
    e_chid   = m_chid;
    e_ack    = (m_valid && rdy) ? (one << m_chid) : '0;
    e_sticky = m_sticky;
    e_any    = m_any;
    model_step(r, en, req, rdy, err, clr);
    @(posedge clk);
    #1;
  endtask

  logic [NUM_CH-1:0] all1;
  logic [NUM_CH-1:0] none;
  logic [NUM_CH-1:0] one_v;
  logic [NUM_CH-1:0] exp_ack;
  logic [NUM_CH-1:0] r_en, r_req, r_err;
  logic              r_rdy, r_clr, r_rst;

  initial begin
    all1 = '1;
    none = '0;
    one_v = 1;
    rst = 1'b1;
    i_enable_chid = '0;
    i_req_chid = '0;
    i_ready = 1'b0;
    i_error_chid = '0;
    i_err_clr = 1'b0;
    m_valid = 1'b0; m_chid = 0; m_last = NUM_CH - 1; m_sticky = '0; m_any = 1'b0;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, none, none, 1'b0, none, 1'b0);
    drive_cycle(1'b0, all1, none, 1'b1, none, 1'b0);
    check("reset valid", s_valid, 1'b0);
    check("reset chid", s_chid, 0);
    check("reset sticky", s_sticky, 0);
    check("reset any", s_any, 1'b0);
    check("idle ready ack", s_ack, 0);

    // rst, en, req, rdy, chk, ev, cc, echid
    // IDs 3,10,79 rotate one per cycle, 1-cycle initial latency
    add(1, all1, none, 0, 0, 0, 0, 0);
    add(0, all1, bit_of(3) | bit_of(10) | bit_of(79), 1, 1, 0, 0, 0);
    add(0, all1, bit_of(3) | bit_of(10) | bit_of(79), 1, 1, 1, 1, 3);
    add(0, all1, bit_of(3) | bit_of(10) | bit_of(79), 1, 1, 1, 1, 10);
    add(0, all1, bit_of(3) | bit_of(10) | bit_of(79), 1, 1, 1, 1, 79);
    add(0, all1, bit_of(3) | bit_of(10) | bit_of(79), 1, 1, 1, 1, 3);
    add(0, all1, bit_of(3) | bit_of(10) | bit_of(79), 0, 1, 1, 1, 10);
    // ID 5 held through backpressure, acked only on the ready cycle
    add(1, all1, none, 0, 0, 0, 0, 0);
    add(0, all1, bit_of(5), 0, 1, 0, 0, 0);
    add(0, all1, bit_of(5), 0, 1, 1, 1, 5);
    add(0, all1, bit_of(5), 0, 1, 1, 1, 5);
    add(0, all1, bit_of(5), 0, 1, 1, 1, 5);
    add(0, all1, bit_of(5), 0, 1, 1, 1, 5);
    add(0, all1, none, 1, 1, 1, 1, 5);
    add(0, all1, none, 1, 1, 0, 0, 0);
    // Enable moves from 0 to 40 while 0 is held
    add(1, all1, none, 0, 0, 0, 0, 0);
    add(0, bit_of(0), all1, 0, 1, 0, 0, 0);
    add(0, bit_of(0), all1, 1, 1, 1, 1, 0);
    add(0, bit_of(40), all1, 0, 1, 1, 1, 0);
    add(0, bit_of(40), all1, 1, 1, 1, 1, 0);
    add(0, bit_of(40), all1, 1, 1, 1, 1, 40);
    add(0, bit_of(40), none, 0, 1, 1, 1, 40);
    // Wrap-around 78 -> 79 -> 1 -> 78
    add(1, all1, none, 0, 0, 0, 0, 0);
    add(0, all1, bit_of(78), 0, 1, 0, 0, 0);
    add(0, all1, bit_of(78) | bit_of(79) | bit_of(1), 1, 1, 1, 1, 78);
    add(0, all1, bit_of(78) | bit_of(79) | bit_of(1), 1, 1, 1, 1, 79);
    add(0, all1, bit_of(78) | bit_of(79) | bit_of(1), 1, 1, 1, 1, 1);
    add(0, all1, bit_of(78) | bit_of(79) | bit_of(1), 0, 1, 1, 1, 78);
    // Reset in HOLD on 20 drops it and restarts the search at 0
    add(1, all1, none, 0, 0, 0, 0, 0);
    add(0, all1, bit_of(30), 0, 1, 0, 0, 0);
    add(0, all1, bit_of(20), 1, 1, 1, 1, 30);
    add(0, all1, bit_of(20), 0, 1, 1, 1, 20);
    add(1, all1, bit_of(20), 0, 1, 1, 1, 20);
    add(0, all1, bit_of(20) | bit_of(50), 0, 1, 0, 1, 0);
    add(0, all1, bit_of(20) | bit_of(50), 0, 1, 1, 1, 20);

    foreach (tv[n]) begin
      drive_cycle(tv[n].rst, tv[n].en, tv[n].req, tv[n].rdy, none, 1'b0);
      if (tv[n].chk) begin
        check($sformatf("tv%0d valid", n), s_valid, tv[n].ev);
        exp_ack = (tv[n].ev && tv[n].rdy) ? (one_v << tv[n].echid) : '0;
        check($sformatf("tv%0d ack", n), s_ack, exp_ack);
      end
      if (tv[n].cc) check($sformatf("tv%0d chid", n), s_chid, tv[n].echid);
    end

    // Sticky error sequence
    drive_cycle(1'b1, all1, none, 1'b0, none, 1'b0);
    drive_cycle(1'b0, all1, none, 1'b0, bit_of(7), 1'b1);
    drive_cycle(1'b0, all1, none, 1'b0, none, 1'b0);
`ifdef ODU_SCHED_ERR_STICKY_EN
    check("err set wins sticky", s_sticky, bit_of(7));
    check("err any lags", s_any, 1'b0);
    drive_cycle(1'b0, all1, none, 1'b0, none, 1'b0);
    check("err any set", s_any, 1'b1);
    drive_cycle(1'b0, all1, none, 1'b0, none, 1'b1);
    drive_cycle(1'b0, all1, none, 1'b0, none, 1'b0);
    check("err clr sticky", s_sticky, 0);
    drive_cycle(1'b0, ~bit_of(12), none, 1'b0, bit_of(12), 1'b0);
    drive_cycle(1'b0, all1, none, 1'b0, none, 1'b0);
    check("err clr any", s_any, 1'b0);
    check("err disabled ch", s_sticky, 0);
`else
    check("err tied sticky", s_sticky, 0);
    check("err tied any", s_any, 1'b0);
`endif

    // Randomized traffic against the model
    drive_cycle(1'b1, none, none, 1'b0, none, 1'b0);
    for (int t = 0; t < 3000; t++) begin
      r_en  = ($urandom_range(1) == 0) ? all1 : '0;
      r_req = '0;
      r_err = '0;
      for (int j = 0; j < NUM_CH; j++) begin
        if (r_en != all1) r_en[j] = ($urandom_range(3) != 0);
        r_req[j] = ($urandom_range(9) == 0);
        r_err[j] = ($urandom_range(39) == 0);
      end
      r_rdy = ($urandom_range(3) != 0);
      r_clr = ($urandom_range(15) == 0);
      r_rst = ($urandom_range(199) == 0);
      drive_cycle(r_rst, r_en, r_req, r_rdy, r_err, r_clr);
      check($sformatf("rnd%0d valid", t), s_valid, e_valid);
      if (e_valid) check($sformatf("rnd%0d chid", t), s_chid, e_chid);
      check($sformatf("rnd%0d ack", t), s_ack, e_ack);
      check($sformatf("rnd%0d sticky", t), s_sticky, e_sticky);
      check($sformatf("rnd%0d any", t), s_any, e_any);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
